// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage F/D/E/M/W pipeline.
// It produces the stall, flush and forwarding controls, and latches a sticky error when a data-memory access times out.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemToRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemErr
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ldr_stall;
  logic pc_wr_pend;
  logic mem_stall;

  // R15 is the PC and is never forwarded; the M stage has priority over the W stage.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic [3:0] wa_m,
    input logic       we_m,
    input logic [3:0] wa_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'hF) begin
      if (we_m && (ra == wa_m))      sel = 2'b10;
      else if (we_w && (ra == wa_w)) sel = 2'b01;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign ldr_stall  = MemToRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;
  assign mem_stall  = MemReqM & ~MemReadyM;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter tracks consecutive un-acked cycles, so the first stalled cycle already counts as 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          cnt_d   = sat_inc(cnt_q);
        end else begin
          cnt_d   = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          if (cnt_q == CNT_LAST) state_d = ERROR;
          cnt_d = sat_inc(cnt_q);
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset forces the outputs directly, so they are well defined while RESET_N is low, whatever the other inputs are.
  always_comb begin
    ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
    ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
    StallF    = ldr_stall | pc_wr_pend;
    StallD    = ldr_stall;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = pc_wr_pend | PCSrcW | BranchTakenE;
    FlushE    = ldr_stall | BranchTakenE;
    FlushW    = 1'b0;
    MemErr    = 1'b0;

    if (!RESET_N) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
    end else if ((state_q == ERROR) || mem_stall) begin
      // Freeze everything and drop bubbles into W. Any branch flush stays pending until M advances.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
      MemErr = (state_q == ERROR);
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipelined CPU (F/D/E/M/W).
- Drives the stall and flush inputs of the F, D, E, M and W pipeline registers.
- Produces the E-stage operand forwarding selects.
- Holds the whole pipeline while the data memory has not acknowledged an M-stage access; a timeout FSM latches a sticky error.

Parameters:
- MEM_TIMEOUT, 255: consecutive un-acked memory-stall cycles before entering ERROR. Legal range 2..65535.
- CNT_W, $clog2(MEM_TIMEOUT+1): width of the wait counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- RA1D, RA2D  in  4 each  source registers of the instruction in D.
- RA1E, RA2E  in  4 each  source registers of the instruction in E.
- WA3E, WA3M, WA3W  in  4 each  destination registers in E, M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables per stage.
- MemToRegE  in  1  instruction in E is a load.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  instruction writes the PC (R15), per stage.
- BranchTakenE  in  1  branch resolved taken in E.
- MemReqM  in  1  instruction in M accesses data memory.
- MemReadyM  in  1  data memory acknowledges the access this cycle.
- ForwardAE, ForwardBE  out  2 each  operand select: 00 = register file, 01 = W result, 10 = M ALU result.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1 each  load a bubble into the D, E or W register.
- MemErr  out  1  sticky memory-timeout flag.

Behaviour:
- States: RUN, MEM_WAIT, ERROR. The state register and wait counter are the only flops; all other outputs are combinational from state and inputs.
- Reset (RESET_N=0, asynchronous):
  - state=RUN, counter=0, MemErr=0.
  - StallF/D/E/M=0, FlushD=FlushE=FlushW=1, ForwardAE=ForwardBE=00, all independent of other inputs.
  - Reset asserted in any state, including mid-wait, aborts immediately.
- Forwarding, computed in all states:
  - ForwardAE=10 if RegWriteM and RA1E==WA3M; else 01 if RegWriteW and RA1E==WA3W; else 00.
  - M has priority over W.
  - RA1E==4'hF never forwards.
  - ForwardBE is identical using RA2E.
- Hazard terms:
  - LDRstall = MemToRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
  - PCWrPend = PCSrcD|PCSrcE|PCSrcM.
  - MemStall = MemReqM & !MemReadyM.
- RUN outputs, MemStall=0:
  - StallF = LDRstall|PCWrPend.
  - StallD = LDRstall.
  - StallE = StallM = 0.
  - FlushD = PCWrPend|PCSrcW|BranchTakenE.
  - FlushE = LDRstall|BranchTakenE.
  - FlushW = 0.
- RUN or MEM_WAIT with MemStall=1:
  - StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0.
  - Memory stall overrides load-use stalls and branch flushes; the held branch flushes on the first non-stalled cycle.
- MEM_WAIT with MemReadyM=1 (same cycle): RUN output equations apply, M advances, next state=RUN.
- Transitions:
  - RUN→MEM_WAIT when MemStall.
  - MEM_WAIT→RUN when !MemStall; MemReqM dropping also exits.
  - MEM_WAIT→ERROR when MemStall and counter==MEM_TIMEOUT-1.
  - ERROR is exited only by reset.
- Counter:
  - Increments on each MemStall cycle in RUN/MEM_WAIT; the first stalled cycle counts as 1.
  - Clears to 0 on any non-MemStall cycle.
  - ERROR is entered after exactly MEM_TIMEOUT consecutive stall cycles.
  - Never wraps.
- ERROR: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0, MemErr=1. Forwarding outputs continue normally.

Test Plan:
- Reset check: RESET_N=0 with random inputs → Stall*=0, FlushD/E/W=1, Forward*=00, MemErr=0. Release → RUN with all-quiet outputs.
- Forwarding:
  - RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 → ForwardAE=10.
  - Same with RegWriteM=0 → 01.
  - RA2E=15, WA3M=15 → ForwardBE=00.
- Load-use: MemToRegE=1, RegWriteE=1, WA3E=5, RA2D=5 → StallF=StallD=FlushE=1 for one cycle; no stall when RA1D=RA2D=6.
- Branch: BranchTakenE=1 → FlushD=FlushE=1. PCSrcD=1 → StallF=FlushD=1, FlushE=0.
- Memory wait: MemReqM=1 with MemReadyM low for 3 cycles, then high.
  - 3 cycles of all-stall plus FlushW=1.
  - Ack cycle shows RUN outputs.
  - BranchTakenE held during the wait flushes only on the ack cycle.
  - Counter returns to 0.
- Timeout: MEM_TIMEOUT=4, MemReadyM held low.
  - MemErr=1 after the 4th stall edge, stall persists with MemReadyM=1.
  - RESET_N pulse mid-ERROR clears MemErr asynchronously.
